// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game-state FSM, balls-remaining counter, inter-ball delay timer.
// Optional build macro BONUS_BALL_EN: a hit while dig0 == 9 awards an extra ball.
module pong_game_ctrl #(
  parameter int NUM_BALLS   = 3,
  parameter int BALL_W      = 2,
  parameter int TIMER_TICKS = 120,
  parameter int TIMER_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        btn,
  input  logic              refr_tick,
  input  logic              hit,
  input  logic              miss,
  input  logic [3:0]        dig0,
  output logic              d_inc,
  output logic              d_clr,
  output logic              graph_still,
  output logic              ball_reload,
  output logic [BALL_W-1:0] balls_left,
  output logic [1:0]        game_state
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [BALL_W-1:0]  NB = BALL_W'(NUM_BALLS);
  localparam logic [TIMER_W-1:0] TT = TIMER_W'(TIMER_TICKS);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [BALL_W-1:0]  bl_after_miss;
  logic [BALL_W-1:0]  bl_play;
  logic               pressed;

  assign pressed    = (btn != 2'b00);
  assign game_state = state;

  // Ball count for the next PLAY cycle; the miss decision always sees the pre-bonus value.
  always_comb begin
    bl_after_miss = (miss && balls_left != '0) ? balls_left - BALL_W'(1) : balls_left;
    bl_play       = bl_after_miss;
`ifdef BONUS_BALL_EN
    if (hit && dig0 == 4'd9 && bl_after_miss < NB)
      bl_play = bl_after_miss + BALL_W'(1);
`endif
  end

`ifndef BONUS_BALL_EN
  logic unused_dig0;
  assign unused_dig0 = ^dig0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= NEWGAME;
      balls_left  <= NB;
      timer       <= '0;
      d_inc       <= 1'b0;
      d_clr       <= 1'b0;
      ball_reload <= 1'b0;
      graph_still <= 1'b1;
    end else begin
      d_inc       <= 1'b0;
      d_clr       <= 1'b0;
      ball_reload <= 1'b0;
      if ((state == NEWBALL || state == OVER) && refr_tick && timer != '0)
        timer <= timer - TIMER_W'(1);
      case (state)
        NEWGAME: begin
          if (pressed) begin
            state       <= PLAY;
            d_clr       <= 1'b1;
            ball_reload <= 1'b1;
            balls_left  <= NB - BALL_W'(1);
            graph_still <= 1'b0;
          end
        end
        PLAY: begin
          if (hit) d_inc <= 1'b1;
          if (miss) begin
            timer       <= TT;
            graph_still <= 1'b1;
            state       <= (balls_left == '0) ? OVER : NEWBALL;
          end
          // On the transition to OVER any bonus is dropped (count stays 0).
          if (!(miss && balls_left == '0))
            balls_left <= bl_play;
        end
        NEWBALL: begin
          if (timer == '0 && pressed) begin
            state       <= PLAY;
            ball_reload <= 1'b1;
            graph_still <= 1'b0;
          end
        end
        default: begin
          if (timer == '0) begin
            state      <= NEWGAME;
            balls_left <= NB;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: expectations queued per driven cycle, popped at the sampling edge.
module tb_pong_game_ctrl;

`ifdef BONUS_BALL_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn = 2'b00;
  logic       refr_tick = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [3:0] dig0 = 4'd0;
  logic       d_inc, d_clr, graph_still, ball_reload;
  logic [1:0] balls_left, game_state;

  int total = 0;
  int bad = 0;
  int dinc_cnt = 0;
  logic [1:0] exp_bl;

  typedef struct {
    logic [1:0] st;
    logic [1:0] bl;
    logic       still, di, dc, rl;
  } exp_t;
  exp_t sb[$];

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .btn(btn), .refr_tick(refr_tick), .hit(hit), .miss(miss),
    .dig0(dig0), .d_inc(d_inc), .d_clr(d_clr), .graph_still(graph_still),
    .ball_reload(ball_reload), .balls_left(balls_left), .game_state(game_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (d_inc) dinc_cnt <= dinc_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic cyc(input string tag, input logic [1:0] b, input logic t, h, m,
                     input logic [1:0] st, bl, input logic still, di, dc, rl);
    exp_t e;
    btn = b; refr_tick = t; hit = h; miss = m;
    e.st = st; e.bl = bl; e.still = still; e.di = di; e.dc = dc; e.rl = rl;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    btn = 2'b00; refr_tick = 1'b0; hit = 1'b0; miss = 1'b0;
    e = sb.pop_front();
    chk({tag, ".state"}, int'(game_state), int'(e.st));
    chk({tag, ".balls"}, int'(balls_left), int'(e.bl));
    chk({tag, ".still"}, int'(graph_still), int'(e.still));
    chk({tag, ".d_inc"}, int'(d_inc), int'(e.di));
    chk({tag, ".d_clr"}, int'(d_clr), int'(e.dc));
    chk({tag, ".reload"}, int'(ball_reload), int'(e.rl));
  endtask

  task automatic ticks(input string tag, input int n, input logic [1:0] b,
                       input logic [1:0] st, bl);
    for (int i = 0; i < n; i++) cyc(tag, b, 1'b1, 1'b0, 1'b0, st, bl, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.state", int'(game_state), 0);
    chk("rst.balls", int'(balls_left), 3);
    chk("rst.still", int'(graph_still), 1);
    chk("rst.pulses", int'({d_inc, d_clr, ball_reload}), 0);
    reset = 1'b0;

    // Game 1
    cyc("idle_ng", 2'b00, 0, 0, 0, 2'd0, 2'd3, 1, 0, 0, 0);
    cyc("hit_ng", 2'b00, 0, 1, 0, 2'd0, 2'd3, 1, 0, 0, 0);
    cyc("start", 2'b01, 0, 0, 0, 2'd1, 2'd2, 0, 0, 1, 1);
    cyc("start+1", 2'b00, 0, 0, 0, 2'd1, 2'd2, 0, 0, 0, 0);
    dinc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc("hit", 2'b00, 0, 1, 0, 2'd1, 2'd2, 0, 1, 0, 0);
      repeat (4) cyc("hit_gap", 2'b00, 0, 0, 0, 2'd1, 2'd2, 0, 0, 0, 0);
    end
    chk("score", dinc_cnt, 3);

    cyc("miss1", 2'b00, 0, 0, 1, 2'd2, 2'd1, 1, 0, 0, 0);
    cyc("nb_hit", 2'b10, 1, 1, 0, 2'd2, 2'd1, 1, 0, 0, 0);
    ticks("nb_wait", 119, 2'b10, 2'd2, 2'd1);
    cyc("serve", 2'b10, 0, 0, 0, 2'd1, 2'd1, 0, 0, 0, 1);

    // Bonus hits at dig0 == 9
    exp_bl = 2'd1;
    dig0 = 4'd9;
    for (int i = 0; i < 3; i++) begin
      if (BONUS && exp_bl < 2'd3) exp_bl = exp_bl + 2'd1;
      cyc("bonus", 2'b00, 0, 1, 0, 2'd1, exp_bl, 0, 1, 0, 0);
      cyc("bonus_gap", 2'b00, 0, 0, 0, 2'd1, exp_bl, 0, 0, 0, 0);
    end
    dig0 = 4'd0;

    while (exp_bl != 2'd0) begin
      exp_bl = exp_bl - 2'd1;
      cyc("miss", 2'b00, 0, 0, 1, 2'd2, exp_bl, 1, 0, 0, 0);
      ticks("delay", 120, 2'b00, 2'd2, exp_bl);
      cyc("no_btn", 2'b00, 0, 0, 0, 2'd2, exp_bl, 1, 0, 0, 0);
      cyc("reserve", 2'b01, 0, 0, 0, 2'd1, exp_bl, 0, 0, 0, 1);
    end

    dig0 = 4'd9;
    cyc("hitmiss0", 2'b00, 0, 1, 1, 2'd3, 2'd0, 1, 1, 0, 0);
    dig0 = 4'd0;
    cyc("over+1", 2'b00, 0, 0, 0, 2'd3, 2'd0, 1, 0, 0, 0);
    ticks("over_half", 60, 2'b11, 2'd3, 2'd0);

    // Reset in the middle of OVER
    reset = 1'b1;
    #1;
    chk("arst.state", int'(game_state), 0);
    chk("arst.timer", int'(dut.timer), 0);
    @(negedge clk);
    chk("arst.balls", int'(balls_left), 3);
    chk("arst.pulses", int'({d_inc, d_clr, ball_reload}), 0);
    chk("arst.still", int'(graph_still), 1);
    reset = 1'b0;
    cyc("post_rst", 2'b00, 0, 0, 0, 2'd0, 2'd3, 1, 0, 0, 0);

    // Game 2: play through to OVER and back to NEWGAME
    cyc("g2_start", 2'b10, 0, 0, 0, 2'd1, 2'd2, 0, 0, 1, 1);
    for (int b = 1; b >= 0; b--) begin
      cyc("g2_miss", 2'b00, 0, 0, 1, 2'd2, 2'(b), 1, 0, 0, 0);
      ticks("g2_delay", 120, 2'b01, 2'd2, 2'(b));
      cyc("g2_serve", 2'b01, 0, 0, 0, 2'd1, 2'(b), 0, 0, 0, 1);
    end
    cyc("g2_over", 2'b00, 0, 0, 1, 2'd3, 2'd0, 1, 0, 0, 0);
    ticks("g2_over_wait", 120, 2'b01, 2'd3, 2'd0);
    cyc("g2_newgame", 2'b01, 0, 0, 0, 2'd0, 2'd3, 1, 0, 0, 0);
    cyc("g2_ng_idle", 2'b00, 0, 0, 0, 2'd0, 2'd3, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
